// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants and swap FSM encoding for the dual-bank framebuffer
package fb_pkg;

  localparam int DEF_FB_WIDTH  = 400;
  localparam int DEF_FB_HEIGHT = 240;
  localparam int DEF_COLOR_W   = 16;

  localparam int FB_ADDR_W = $clog2(DEF_FB_WIDTH * DEF_FB_HEIGHT);
  localparam int FB_X_W    = $clog2(DEF_FB_WIDTH) + 1;
  localparam int FB_Y_W    = $clog2(DEF_FB_HEIGHT) + 1;

  // Pixel bit 0 marks transparency; the framebuffer stores it untouched.
  localparam int TRANSPARENT_BIT = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

endpackage

// File: rtl/fb_bank_ram.sv
// rtl/fb_bank_ram.sv - simple dual-port bank RAM, one write port and one registered read port
module fb_bank_ram #(
  parameter int DEPTH  = 96000,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/framebuffer_dual.sv
// rtl/framebuffer_dual.sv - double-buffered framebuffer: GPU writes the back bank, scanout reads the front bank
module framebuffer_dual
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = DEF_FB_WIDTH,
  parameter int FB_HEIGHT = DEF_FB_HEIGHT,
  parameter int COLOR_W   = DEF_COLOR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(FB_WIDTH):0]  wr_x,
  input  logic [$clog2(FB_HEIGHT):0] wr_y,
  input  logic [COLOR_W-1:0]         wr_color,
  input  logic                       wr_en,
  input  logic [$clog2(FB_WIDTH):0]  rd_x,
  input  logic [$clog2(FB_HEIGHT):0] rd_y,
  input  logic                       rd_en,
  output logic [COLOR_W-1:0]         rd_color,
  output logic                       rd_valid,
  input  logic                       swap_req,
  input  logic                       vblank,
  output logic                       swap_pending,
  output logic                       front_sel
);

  localparam int DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_in, wr_go;
  logic              rd_in, rd_go;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [COLOR_W-1:0] q0, q1;

  logic        s1_valid, s1_in, s1_bank;
  swap_state_t state;
  logic        req_q, vblank_q;
  logic        req_rise, vblank_rise;

  // Linear address is formed at 32 bits and only narrowed once the coordinates are known in range.
  assign wr_in   = (32'(wr_x) < 32'(FB_WIDTH)) && (32'(wr_y) < 32'(FB_HEIGHT));
  assign wr_go   = wr_en && wr_in;
  assign wr_addr = wr_in ? ADDR_W'(32'(wr_y) * 32'(FB_WIDTH) + 32'(wr_x)) : '0;

  assign rd_in   = (32'(rd_x) < 32'(FB_WIDTH)) && (32'(rd_y) < 32'(FB_HEIGHT));
  assign rd_go   = rd_en && rd_in;
  assign rd_addr = rd_in ? ADDR_W'(32'(rd_y) * 32'(FB_WIDTH) + 32'(rd_x)) : '0;

  fb_bank_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(COLOR_W)
  ) u_bank0 (
    .clk  (clk),
    .we   (wr_go && front_sel),
    .waddr(wr_addr),
    .wdata(wr_color),
    .re   (rd_go && !front_sel),
    .raddr(rd_addr),
    .rdata(q0)
  );

  fb_bank_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(COLOR_W)
  ) u_bank1 (
    .clk  (clk),
    .we   (wr_go && !front_sel),
    .waddr(wr_addr),
    .wdata(wr_color),
    .re   (rd_go && front_sel),
    .raddr(rd_addr),
    .rdata(q1)
  );

  // The bank is captured with the request, so a swap landing mid-read cannot redirect it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_in    <= 1'b0;
      s1_bank  <= 1'b0;
      rd_valid <= 1'b0;
      rd_color <= '0;
    end else begin
      s1_valid <= rd_en;
      s1_in    <= rd_in;
      s1_bank  <= front_sel;
      rd_valid <= s1_valid;
      rd_color <= (s1_valid && s1_in) ? (s1_bank ? q1 : q0) : '0;
    end
  end

  assign req_rise    = swap_req && !req_q;
  assign vblank_rise = vblank && !vblank_q;

  // Edge history tracks the live level during reset so a level held across reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      req_q        <= swap_req;
      vblank_q     <= vblank;
    end else begin
      req_q    <= swap_req;
      vblank_q <= vblank;
      case (state)
        IDLE: begin
          if (req_rise) begin
            if (vblank_rise) begin
              front_sel <= !front_sel;
            end else begin
              state        <= PENDING;
              swap_pending <= 1'b1;
            end
          end
        end
        PENDING: begin
          if (vblank_rise) begin
            front_sel    <= !front_sel;
            state        <= IDLE;
            swap_pending <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_dual.sv
// tb/tb_framebuffer_dual.sv - directed and randomized bench for framebuffer_dual against a behavioural model
module tb_framebuffer_dual;

  localparam int W = 400;
  localparam int H = 240;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  wr_x, rd_x;
  logic [8:0]  wr_y, rd_y;
  logic [15:0] wr_color;
  logic        wr_en, rd_en;
  logic [15:0] rd_color;
  logic        rd_valid;
  logic        swap_req, vblank;
  logic        swap_pending, front_sel;

  framebuffer_dual dut (
    .clk         (clk),
    .reset       (reset),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .wr_en       (wr_en),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_en       (rd_en),
    .rd_color    (rd_color),
    .rd_valid    (rd_valid),
    .swap_req    (swap_req),
    .vblank      (vblank),
    .swap_pending(swap_pending),
    .front_sel   (front_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          known;
    logic [15:0] c;
  } rd_exp_t;

  int          checks = 0;
  int          errors = 0;
  rd_exp_t     pipe[$];
  logic [15:0] mem[int];
  bit          m_front, m_pending, m_req_prev, m_vb_prev;

  function automatic int key(bit b, int x, int y);
    return (b ? 1000000 : 0) + y * W + x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model consumes the inputs the DUT samples at this edge, then outputs are compared.
  task automatic cycle();
    rd_exp_t e, o;
    bit      req_edge, vb_edge;
    e = '{v: 1'b0, known: 1'b0, c: 16'h0};
    if (reset) begin
      m_front    = 1'b0;
      m_pending  = 1'b0;
      m_req_prev = swap_req;
      m_vb_prev  = vblank;
      pipe.delete();
      pipe.push_back(e);
      o = e;
    end else begin
      if (wr_en && int'(wr_x) < W && int'(wr_y) < H)
        mem[key(!m_front, int'(wr_x), int'(wr_y))] = wr_color;
      e.v = rd_en;
      if (rd_en) begin
        if (int'(rd_x) < W && int'(rd_y) < H) begin
          if (mem.exists(key(m_front, int'(rd_x), int'(rd_y)))) begin
            e.known = 1'b1;
            e.c     = mem[key(m_front, int'(rd_x), int'(rd_y))];
          end
        end else begin
          e.known = 1'b1;
        end
      end
      pipe.push_back(e);
      o = pipe.pop_front();
      req_edge = swap_req && !m_req_prev;
      vb_edge  = vblank && !m_vb_prev;
      if (!m_pending) begin
        if (req_edge) begin
          if (vb_edge) m_front = !m_front;
          else m_pending = 1'b1;
        end
      end else if (vb_edge) begin
        m_front   = !m_front;
        m_pending = 1'b0;
      end
      m_req_prev = swap_req;
      m_vb_prev  = vblank;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", rd_valid, o.v);
    if (reset) chk("rd_color_reset", rd_color, 16'h0);
    else if (o.v && o.known) chk("rd_color", rd_color, o.c);
    chk("front_sel", front_sel, m_front);
    chk("swap_pending", swap_pending, m_pending);
  endtask

  task automatic wr(input int x, input int y, input logic [15:0] c);
    wr_x = 10'(x); wr_y = 9'(y); wr_color = c; wr_en = 1'b1;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int x, input int y);
    rd_x = 10'(x); rd_y = 9'(y); rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1; cycle();
    swap_req = 1'b0; cycle();
    vblank = 1'b1;   cycle();
    vblank = 1'b0;   cycle();
  endtask

  initial begin
    reset = 1'b1;
    wr_x = '0; wr_y = '0; wr_color = '0; wr_en = 1'b0;
    rd_x = '0; rd_y = '0; rd_en = 1'b0;
    swap_req = 1'b0; vblank = 1'b0;
    repeat (3) cycle();
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_rd_color", rd_color, 16'h0);
    reset = 1'b0;

    // Read right after reset: valid two edges later, no swap activity.
    rd(0, 0);
    cycle();
    chk("first_read_valid", rd_valid, 1'b1);
    chk("first_front", front_sel, 1'b0);
    chk("first_pending", swap_pending, 1'b0);

    // Writes stay invisible until a swap.
    wr(10, 5, 16'h1234);
    do_swap();
    chk("swap1_front", front_sel, 1'b1);
    wr(10, 5, 16'hF801);
    rd(10, 5);
    cycle();
    chk("old_value", rd_color, 16'h1234);
    do_swap();
    chk("swap2_front", front_sel, 1'b0);
    rd(10, 5);
    cycle();
    chk("new_value", rd_color, 16'hF801);

    // Out-of-range writes must not alias onto real pixels.
    wr(0, 0, 16'h0AAA);
    wr(399, 239, 16'h0BBB);
    wr(0, 1, 16'h0CCC);
    wr(400, 0, 16'hFFFF);
    wr(0, 240, 16'hFFFF);
    do_swap();
    rd_en = 1'b1;
    rd_x = 10'd0;   rd_y = 9'd0;   cycle();
    rd_x = 10'd399; rd_y = 9'd239; cycle();
    chk("corner00", rd_color, 16'h0AAA);
    rd_x = 10'd0;   rd_y = 9'd1;   cycle();
    chk("corner_far", rd_color, 16'h0BBB);
    rd_x = 10'd400; rd_y = 9'd0;   cycle();
    chk("alias01", rd_color, 16'h0CCC);
    rd_x = 10'd0;   rd_y = 9'd240; cycle();
    chk("oor_valid", rd_valid, 1'b1);
    chk("oor_color", rd_color, 16'h0);
    rd_en = 1'b0;
    cycle(); cycle();

    // Request during blanking waits for the next vblank edge; second request is absorbed.
    vblank = 1'b1; cycle(); cycle();
    swap_req = 1'b1; cycle();
    chk("pend_set", swap_pending, 1'b1);
    chk("pend_no_toggle", front_sel, 1'b1);
    cycle(); cycle();
    chk("pend_hold_front", front_sel, 1'b1);
    swap_req = 1'b0; vblank = 1'b0; cycle();
    swap_req = 1'b1; cycle();
    swap_req = 1'b0; cycle();
    vblank = 1'b1; cycle();
    chk("pend_toggle", front_sel, 1'b0);
    chk("pend_clear", swap_pending, 1'b0);
    vblank = 1'b0; cycle();
    vblank = 1'b1; cycle();
    chk("single_toggle", front_sel, 1'b0);
    vblank = 1'b0; cycle();

    // Simultaneous request and vblank edge: immediate swap, in-flight read keeps old front.
    rd_x = 10'd10; rd_y = 9'd5; rd_en = 1'b1; cycle();
    rd_en = 1'b0; swap_req = 1'b1; vblank = 1'b1; cycle();
    chk("simul_front", front_sel, 1'b1);
    chk("simul_pending", swap_pending, 1'b0);
    chk("simul_old_front", rd_color, 16'hF801);
    swap_req = 1'b0; vblank = 1'b0; cycle();
    chk("simul_pending2", swap_pending, 1'b0);

    // Reset while pending with reads in flight; swap_req held high across reset.
    swap_req = 1'b1; rd_en = 1'b1; cycle();
    chk("rst_pre_pending", swap_pending, 1'b1);
    cycle();
    reset = 1'b1; rd_en = 1'b0; cycle();
    chk("rst_pending", swap_pending, 1'b0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_front", front_sel, 1'b0);
    reset = 1'b0; cycle();
    vblank = 1'b1; cycle(); cycle();
    chk("rst_no_toggle", front_sel, 1'b0);
    chk("rst_no_pending", swap_pending, 1'b0);
    swap_req = 1'b0; vblank = 1'b0; cycle();

    // Randomized traffic in a small window plus occasional boundary and out-of-range coordinates.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      wr_en = !reset && ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 5))
        0:       begin wr_x = 10'($urandom_range(0, 1023)); wr_y = 9'($urandom_range(0, 511)); end
        1:       begin wr_x = 10'($urandom_range(398, 401)); wr_y = 9'($urandom_range(238, 241)); end
        default: begin wr_x = 10'($urandom_range(0, 7)); wr_y = 9'($urandom_range(0, 3)); end
      endcase
      wr_color = 16'($urandom);
      rd_en = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0:       begin rd_x = 10'($urandom_range(0, 1023)); rd_y = 9'($urandom_range(0, 511)); end
        1:       begin rd_x = 10'($urandom_range(398, 401)); rd_y = 9'($urandom_range(238, 241)); end
        default: begin rd_x = 10'($urandom_range(0, 7)); rd_y = 9'($urandom_range(0, 3)); end
      endcase
      if ($urandom_range(0, 5) == 0) swap_req = !swap_req;
      if ($urandom_range(0, 7) == 0) vblank = !vblank;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
